uart_rx: RTL and testbench

UART receiver core and the receive-side counterpart of the existing 8N1 transmitter.
- Deserializes 8N1 frames (1 start LOW, DATA_WIDTH data bits LSB first, 1 stop HIGH) from the asynchronous rx_serial line.
- Oversamples at 16x baud, using the shared baud_tick from the baud generator.
- Presents each received word on a valid/ready output interface.
- Flags framing errors and overruns; the host-side FIFO/CSR block consumes these.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled on the shared baud_tick,
// with a valid/ready output and framing-error/overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: when defined, each sample point
// takes a 2-of-3 majority over the current and two previous baud ticks.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic                  rx_active
);

    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    rx_s;
    logic                    sample;
    logic                    armed;
    logic                    armed_nxt;
    logic [3:0]              os_cnt;
    logic [3:0]              os_nxt;
    logic [BW-1:0]           bit_cnt;
    logic [BW-1:0]           bit_nxt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic                    word_done;
    logic                    frame_bad;

    // Bring the asynchronous serial line into the clock domain; idles HIGH.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rx_serial};
    end

    assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous tick samples so a sample point can out-vote a spike.
    always_ff @(posedge uart_clk) begin
        if (!rst_n)         hist <= '1;
        else if (baud_tick) hist <= {hist[0], rx_s};
    end

    assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rx_s;
`endif

    // Frame sequencing: decide next state, counters and shifter on each baud tick.
    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        os_nxt    = os_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        word_done = 1'b0;
        frame_bad = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt = START;
                        os_nxt    = 4'd0;
                        armed_nxt = 1'b0;
                    end
                end
                START: begin
                    os_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd7) begin
                        if (!sample) begin
                            state_nxt = DATA;
                            os_nxt    = 4'd0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    os_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        shift_nxt = {sample, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            state_nxt = STOP;
                            os_nxt    = 4'd0;
                            bit_nxt   = '0;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    os_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        state_nxt = IDLE;
                        if (sample) word_done = 1'b1;
                        else        frame_bad = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Register the sequencing state; reset aborts any frame in flight.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            os_cnt    <= 4'd0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            armed     <= armed_nxt;
            os_cnt    <= os_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
        end
    end

    // Output holding register, consumer handshake and one-cycle status pulses.
    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            rx_overrun   <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames for uart_rx, checked against a
// word-level model of what each frame should produce (data, error, overrun).
module tb_uart_rx;

    localparam int DW = 8;

    logic          uart_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx_serial = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_overrun;
    logic          rx_active;

    int checks = 0;
    int failures = 0;

    uart_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .uart_clk     (uart_clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_active    (rx_active)
    );

    // 100 MHz-style clock.
    always #5 uart_clk = ~uart_clk;

    // Baud strobe every 4 clocks, changed on the falling edge so it is stable at posedge.
    int tcnt = 0;
    always @(negedge uart_clk) begin
        tcnt = (tcnt + 1) % 4;
        baud_tick = (tcnt == 0);
    end

    // Observed activity at the DUT outputs.
    logic [DW-1:0] got_q[$];
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int seen96 = 0;

    // Record accepted words and status pulses away from the active edge.
    always @(negedge uart_clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                got_q.push_back(rx_data);
                if (rx_data == 8'h96) seen96 = seen96 + 1;
            end
            if (rx_valid)                  valid_cycles = valid_cycles + 1;
            if (rx_frame_err)              ferr_cnt = ferr_cnt + 1;
            if (rx_overrun)                ovr_cnt = ovr_cnt + 1;
            if (rx_frame_err && rx_overrun) both_cnt = both_cnt + 1;
        end
    end

    // Word-level reference: what each complete frame should leave behind.
    logic [DW-1:0] exp_q[$];
    bit            m_full = 1'b0;
    logic [DW-1:0] m_word = '0;
    int            exp_ferr = 0;
    int            exp_ovr = 0;

    task automatic modelFrame(input logic [DW-1:0] d, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (m_full && !rx_ready) begin
            exp_ovr++;
        end else if (rx_ready) begin
            exp_q.push_back(d);
        end else begin
            m_full = 1'b1;
            m_word = d;
        end
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWords();
        checkOutput("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) checkOutput("word_data", int'(got_q[i]), int'(exp_q[i]));
        end
    endtask

    task automatic waitTick();
        do @(posedge uart_clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    // One bit period of 16 ticks; an optional inverted spike lands on tick 8 (the sample tick).
    task automatic driveBit(input logic v, input bit spike);
        for (int t = 0; t < 16; t++) begin
            rx_serial = (spike && t == 8) ? ~v : v;
            waitTick();
        end
    endtask

    task automatic idleBits(input int n);
        for (int i = 0; i < n; i++) driveBit(1'b1, 1'b0);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input bit stop_ok, input bit spike);
        driveBit(1'b0, spike);
        for (int i = 0; i < DW; i++) driveBit(d[i], spike);
        driveBit(stop_ok, spike);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int v0;
        int f0;
        int o0;
        int s0;
        logic [DW-1:0] d;
        bit ok;
        bit prev_bad;

        // Reset state.
        repeat (4) @(posedge uart_clk);
        @(negedge uart_clk);
        checkOutput("rst_data", int'(rx_data), 0);
        checkOutput("rst_valid", int'(rx_valid), 0);
        checkOutput("rst_ferr", int'(rx_frame_err), 0);
        checkOutput("rst_ovr", int'(rx_overrun), 0);
        checkOutput("rst_active", int'(rx_active), 0);
        @(posedge uart_clk);
        #1 rst_n = 1'b1;
        idleBits(2);

        // Single frame with consumer ready.
        $display("[TB] frame 0xA5");
        rx_ready = 1'b1;
        v0 = valid_cycles;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        modelFrame(8'hA5, 1'b1);
        checkOutput("a5_valid_cycles", valid_cycles - v0, 1);
        checkOutput("a5_active_after", int'(rx_active), 0);
        checkOutput("a5_ferr", ferr_cnt, exp_ferr);
        checkWords();

        // Back-to-back frames with consumer stalled.
        $display("[TB] overrun sequence");
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        applyStimulus(8'h00, 1'b1, 1'b0); modelFrame(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0); modelFrame(8'hFF, 1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b0); modelFrame(8'h3C, 1'b1);
        checkOutput("ovr_valid_held", int'(rx_valid), 1);
        checkOutput("ovr_data_kept", int'(rx_data), int'(m_word));
        checkOutput("ovr_pulses", ovr_cnt - o0, 2);
        checkOutput("ovr_model", ovr_cnt, exp_ovr);
        @(posedge uart_clk);
        #1 rx_ready = 1'b1;
        @(posedge uart_clk);
        #1 rx_ready = 1'b0;
        exp_q.push_back(m_word);
        m_full = 1'b0;
        checkOutput("accept_clears", int'(rx_valid), 0);
        checkWords();
        rx_ready = 1'b1;

        // Framing error followed by a long break.
        $display("[TB] break sequence");
        idleBits(1);
        f0 = ferr_cnt;
        v0 = valid_cycles;
        applyStimulus(8'h55, 1'b0, 1'b0); modelFrame(8'h55, 1'b0);
        for (int i = 0; i < 20; i++) driveBit(1'b0, 1'b0);
        idleBits(2);
        applyStimulus(8'h81, 1'b1, 1'b0); modelFrame(8'h81, 1'b1);
        checkOutput("brk_ferr_pulses", ferr_cnt - f0, 1);
        checkOutput("brk_ferr_model", ferr_cnt, exp_ferr);
        checkOutput("brk_valid_cycles", valid_cycles - v0, 1);
        checkWords();

        // Short LOW glitch on the idle line: START entered, abandoned at the mid-bit sample.
        $display("[TB] glitch");
        idleBits(1);
        v0 = valid_cycles;
        f0 = ferr_cnt;
        for (int t = 0; t < 4; t++) begin
            rx_serial = 1'b0;
            waitTick();
        end
        checkOutput("glitch_active_on", int'(rx_active), 1);
        for (int t = 0; t < 4; t++) begin
            rx_serial = 1'b1;
            waitTick();
        end
        checkOutput("glitch_active_hold", int'(rx_active), 1);
        waitTick();
        checkOutput("glitch_active_off", int'(rx_active), 0);
        idleBits(2);
        checkOutput("glitch_no_valid", valid_cycles - v0, 0);
        checkOutput("glitch_no_ferr", ferr_cnt - f0, 0);
        applyStimulus(8'h12, 1'b1, 1'b0); modelFrame(8'h12, 1'b1);
        checkWords();

        // Reset in the middle of data bit 3.
        $display("[TB] reset mid-frame");
        idleBits(1);
        d = 8'hC3;
        driveBit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) driveBit(d[i], 1'b0);
        for (int t = 0; t < 8; t++) begin
            rx_serial = d[3];
            waitTick();
        end
        rst_n = 1'b0;
        rx_serial = 1'b1;
        @(posedge uart_clk);
        @(negedge uart_clk);
        checkOutput("mid_rst_data", int'(rx_data), 0);
        checkOutput("mid_rst_valid", int'(rx_valid), 0);
        checkOutput("mid_rst_ferr", int'(rx_frame_err), 0);
        checkOutput("mid_rst_ovr", int'(rx_overrun), 0);
        checkOutput("mid_rst_active", int'(rx_active), 0);
        @(posedge uart_clk);
        #1 rst_n = 1'b1;
        m_full = 1'b0;
        idleBits(2);
        applyStimulus(8'h7E, 1'b1, 1'b0); modelFrame(8'h7E, 1'b1);
        checkOutput("post_rst_data", int'(rx_data), 8'h7E);
        checkWords();

        // Randomized frames, some with a bad stop bit.
        $display("[TB] random frames");
        prev_bad = 1'b1;
        for (int n = 0; n < 8; n++) begin
            d  = DW'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            idleBits((prev_bad ? 1 : 0) + int'($urandom_range(0, 1)));
            applyStimulus(d, ok, 1'b0);
            modelFrame(d, ok);
            prev_bad = !ok;
        end
        idleBits(1);
        checkWords();
        checkOutput("rand_ferr", ferr_cnt, exp_ferr);
        checkOutput("rand_ovr", ovr_cnt, exp_ovr);

        // Spike on every mid-bit sample tick.
        $display("[TB] spiked frame");
        idleBits(2);
        s0 = seen96;
        applyStimulus(8'h96, 1'b1, 1'b1);
        idleBits(2);
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h96);
        checkOutput("spike_received", seen96 - s0, 1);
        checkOutput("spike_data", int'(rx_data), 8'h96);
`else
        checkOutput("spike_not_received", seen96 - s0, 0);
`endif
        checkWords();
        checkOutput("final_ferr", ferr_cnt, exp_ferr);
        checkOutput("err_ovr_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
